// File: rtl/gate_sweep_pkg.sv
// Shared types and constants for the gate sweep sequencer.
package gate_sweep_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int NUM_VECTORS = 8;
    localparam int VEC_WIDTH   = $clog2(NUM_VECTORS);
    localparam logic [VEC_WIDTH-1:0] LAST_VEC = VEC_WIDTH'(NUM_VECTORS - 1);

    function automatic int hold_cnt_width(input int hold_cycles);
        return $clog2(hold_cycles) + 1;
    endfunction

endpackage

// File: rtl/gate_sweep_ctrl_hold_counter.sv
// Hold timer: counts from its start value towards a terminal value and flags
// terminal count; clear reloads the start value and has priority over enable.
module hold_counter #(
    parameter int               WIDTH      = 3,
    parameter logic [WIDTH-1:0] TERMINAL   = '0,
    parameter bit               COUNT_DOWN = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam logic [WIDTH-1:0] START_VAL = COUNT_DOWN ? TERMINAL : '0;
    localparam logic [WIDTH-1:0] STOP_VAL  = COUNT_DOWN ? '0 : TERMINAL;

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= START_VAL;
        end else if (en) begin
            count <= COUNT_DOWN ? count - 1'b1 : count + 1'b1;
        end
    end

    assign tc = (count == STOP_VAL);

endmodule

// File: rtl/gate_sweep_ctrl.sv
// Drives all eight A/B/C vectors into a combinational gate, samples F at the
// end of each hold window, and grades the resulting truth table.
//
//   state | meaning
//   IDLE  | vectors parked at 000, waiting for start
//   SWEEP | driving vec, sampling F when the hold timer expires
//   DONE  | one-cycle done pulse, results frozen
module gate_sweep_ctrl
    import gate_sweep_pkg::*;
#(
    parameter int                     HOLD_CYCLES = 4,
    parameter logic [NUM_VECTORS-1:0] EXPECTED    = 8'hEA
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    output logic                   A,
    output logic                   B,
    output logic                   C,
    input  logic                   F,
    output logic                   busy,
    output logic                   done,
    output logic                   pass,
    output logic [NUM_VECTORS-1:0] truth_table,
    output logic                   fail_valid,
    output logic [VEC_WIDTH-1:0]   fail_idx
);

    localparam int              HC_W    = hold_cnt_width(HOLD_CYCLES);
    localparam logic [HC_W-1:0] HC_LAST = HC_W'(HOLD_CYCLES - 1);

    state_t                 state, state_nxt;
    logic [VEC_WIDTH-1:0]   vec, vec_nxt;
    logic [NUM_VECTORS-1:0] tt, tt_nxt;
    logic                   pass_q, pass_nxt;
    logic                   fv_q, fv_nxt;
    logic [VEC_WIDTH-1:0]   fidx_q, fidx_nxt;
    logic                   hold_tc;
    logic                   hold_clr;
    logic                   hold_en;

    assign hold_en  = (state == SWEEP);
    assign hold_clr = (state != SWEEP) || hold_tc;

    hold_counter #(
        .WIDTH      (HC_W),
        .TERMINAL   (HC_LAST),
        .COUNT_DOWN (1'b0)
    ) u_hold (
        .clk (clk),
        .rst (rst),
        .clr (hold_clr),
        .en  (hold_en),
        .tc  (hold_tc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            vec    <= '0;
            tt     <= '0;
            pass_q <= 1'b0;
            fv_q   <= 1'b0;
            fidx_q <= '0;
        end else begin
            state  <= state_nxt;
            vec    <= vec_nxt;
            tt     <= tt_nxt;
            pass_q <= pass_nxt;
            fv_q   <= fv_nxt;
            fidx_q <= fidx_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        vec_nxt   = vec;
        tt_nxt    = tt;
        pass_nxt  = pass_q;
        fv_nxt    = fv_q;
        fidx_nxt  = fidx_q;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = SWEEP;
                    vec_nxt   = '0;
                    tt_nxt    = '0;
                    pass_nxt  = 1'b0;
                    fv_nxt    = 1'b0;
                    fidx_nxt  = '0;
                end
            end
            SWEEP: begin
                if (hold_tc) begin
                    tt_nxt[vec] = F;
                    // Vectors run in ascending order, so the first miss is the lowest.
                    if ((F != EXPECTED[vec]) && !fv_q) begin
                        fv_nxt   = 1'b1;
                        fidx_nxt = vec;
                    end
                    if (vec == LAST_VEC) begin
                        state_nxt = DONE;
                        vec_nxt   = '0;
                        pass_nxt  = (tt_nxt == EXPECTED);
                    end else begin
                        vec_nxt = vec + 1'b1;
                    end
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
                vec_nxt   = '0;
            end
        endcase
    end

    // vec is a register and is parked at zero outside SWEEP, so the gate
    // inputs come straight from flops.
    assign A           = vec[2];
    assign B           = vec[1];
    assign C           = vec[0];
    assign busy        = (state == SWEEP);
    assign done        = (state == DONE);
    assign pass        = pass_q;
    assign truth_table = tt;
    assign fail_valid  = fv_q;
    assign fail_idx    = fidx_q;

endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// Self-checking bench for gate_sweep_ctrl: three instances (H=4, H=2, H=1)
// each wired to its own gate model.
module tb_gate_sweep_ctrl;

    localparam int H4 = 4;
    localparam int H2 = 2;
    localparam int H1 = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total  = 0;
    int passed = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // H=4 instance with a selectable gate model
    logic       rst4 = 1'b1, start4 = 1'b0;
    logic       a4, b4, c4, f4, busy4, done4, pass4, fv4;
    logic [7:0] tt4;
    logic [2:0] fidx4;
    logic [2:0] mode4 = 3'd0;

    always_comb begin
        case (mode4)
            3'd0:    f4 = (a4 & b4) | c4;
            3'd1:    f4 = 1'b0;
            3'd2:    f4 = 1'b1;
            3'd3:    f4 = c4;
            3'd4:    f4 = a4 | c4;
            3'd5:    f4 = ((a4 & b4) | c4) & ~(a4 & b4 & c4);
            default: f4 = (a4 & b4) | c4;
        endcase
    end

    gate_sweep_ctrl #(.HOLD_CYCLES(H4), .EXPECTED(8'hEA)) dut4 (
        .clk(clk), .rst(rst4), .start(start4), .A(a4), .B(b4), .C(c4), .F(f4),
        .busy(busy4), .done(done4), .pass(pass4), .truth_table(tt4),
        .fail_valid(fv4), .fail_idx(fidx4)
    );

    // H=2 instance, gate output stuck low
    logic       rst2 = 1'b1, start2 = 1'b0;
    logic       a2, b2, c2, busy2, done2, pass2, fv2;
    logic [7:0] tt2;
    logic [2:0] fidx2;
    logic       f2;
    assign f2 = 1'b0;

    gate_sweep_ctrl #(.HOLD_CYCLES(H2), .EXPECTED(8'hEA)) dut2 (
        .clk(clk), .rst(rst2), .start(start2), .A(a2), .B(b2), .C(c2), .F(f2),
        .busy(busy2), .done(done2), .pass(pass2), .truth_table(tt2),
        .fail_valid(fv2), .fail_idx(fidx2)
    );

    // H=1 instance, real gate
    logic       rst1 = 1'b1, start1 = 1'b0;
    logic       a1, b1, c1, busy1, done1, pass1, fv1, f1;
    logic [7:0] tt1;
    logic [2:0] fidx1;
    assign f1 = (a1 & b1) | c1;

    gate_sweep_ctrl #(.HOLD_CYCLES(H1), .EXPECTED(8'hEA)) dut1 (
        .clk(clk), .rst(rst1), .start(start1), .A(a1), .B(b1), .C(c1), .F(f1),
        .busy(busy1), .done(done1), .pass(pass1), .truth_table(tt1),
        .fail_valid(fv1), .fail_idx(fidx1)
    );

    typedef struct {
        logic [2:0] mode;
        bit         mid_pulse;
        logic [7:0] tt;
        logic       pass;
        logic       fv;
        logic [2:0] fidx;
    } vec_t;

    vec_t tbl[7];

    // One H=4 sweep; checks abc/busy/done every cycle against the ideal schedule.
    task automatic run4(input bit mid_pulse, output int lat, output int busy_n,
                        output int done_n, output int seq_err);
        bit exp_busy;
        int exp_abc;
        lat = -1; busy_n = 0; done_n = 0; seq_err = 0;
        start4 = 1'b1;
        for (int n = 1; n <= 8*H4 + 12; n++) begin
            @(posedge clk); #1;
            start4 = (mid_pulse && n == 10);
            busy_n += int'(busy4);
            done_n += int'(done4);
            if (done4 && lat < 0) lat = n;
            exp_busy = (n <= 8*H4);
            exp_abc  = exp_busy ? (n - 1) / H4 : 0;
            if (busy4 !== exp_busy || {a4, b4, c4} !== 3'(exp_abc) ||
                done4 !== (n == 8*H4 + 1))
                seq_err++;
        end
        start4 = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, busy_n, done_n, seq_err, found, dn, gap_err, seq1_err, perr;
        int done_times[$];
        logic [2:0] abc_log[64];

        tbl[0] = '{3'd0, 1'b0, 8'hEA, 1'b1, 1'b0, 3'd0};
        tbl[1] = '{3'd1, 1'b0, 8'h00, 1'b0, 1'b1, 3'd1};
        tbl[2] = '{3'd2, 1'b0, 8'hFF, 1'b0, 1'b1, 3'd0};
        tbl[3] = '{3'd3, 1'b0, 8'hAA, 1'b0, 1'b1, 3'd6};
        tbl[4] = '{3'd4, 1'b0, 8'hFA, 1'b0, 1'b1, 3'd4};
        tbl[5] = '{3'd5, 1'b0, 8'h6A, 1'b0, 1'b1, 3'd7};
        tbl[6] = '{3'd0, 1'b1, 8'hEA, 1'b1, 1'b0, 3'd0};

        repeat (3) @(posedge clk);
        #1;
        chk("reset_out_h4", {busy4, done4, pass4, tt4, fv4, fidx4, a4, b4, c4}, 0);
        chk("reset_out_h2", {busy2, done2, pass2, tt2, fv2, fidx2, a2, b2, c2}, 0);
        chk("reset_out_h1", {busy1, done1, pass1, tt1, fv1, fidx1, a1, b1, c1}, 0);
        rst4 = 1'b0; rst2 = 1'b0; rst1 = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 7; i++) begin
            mode4 = tbl[i].mode;
            run4(tbl[i].mid_pulse, lat, busy_n, done_n, seq_err);
            chk($sformatf("v%0d_latency", i), lat, 8*H4 + 1);
            chk($sformatf("v%0d_busy_cycles", i), busy_n, 8*H4);
            chk($sformatf("v%0d_done_count", i), done_n, 1);
            chk($sformatf("v%0d_sequence_errs", i), seq_err, 0);
            chk($sformatf("v%0d_truth_table", i), tt4, tbl[i].tt);
            chk($sformatf("v%0d_pass", i), pass4, tbl[i].pass);
            chk($sformatf("v%0d_fail_valid", i), fv4, tbl[i].fv);
            chk($sformatf("v%0d_fail_idx", i), fidx4, tbl[i].fidx);
        end

        // Reset while vector 5 is on the gate
        mode4 = 3'd0;
        start4 = 1'b1;
        found = 0;
        for (int n = 0; n < 100; n++) begin
            @(posedge clk); #1;
            start4 = 1'b0;
            if ({a4, b4, c4} == 3'd5) begin found = 1; break; end
        end
        chk("reach_vec5", found, 1);
        chk("partial_truth_table", tt4, 8'h0A);
        rst4 = 1'b1;
        @(posedge clk); #1;
        rst4 = 1'b0;
        chk("rst_mid_outputs", {busy4, done4, pass4, tt4, fv4, fidx4, a4, b4, c4}, 0);
        dn = 0;
        for (int n = 0; n < 40; n++) begin
            @(posedge clk); #1;
            dn += int'(done4) + int'(busy4);
        end
        chk("rst_no_done_no_busy", dn, 0);
        run4(1'b0, lat, busy_n, done_n, seq_err);
        chk("post_rst_latency", lat, 8*H4 + 1);
        chk("post_rst_truth_table", tt4, 8'hEA);
        chk("post_rst_pass", pass4, 1);

        // H=2, gate stuck at 0
        start2 = 1'b1;
        lat = -1;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk); #1;
            start2 = 1'b0;
            if (done2 && lat < 0) lat = n;
        end
        chk("h2_latency", lat, 8*H2 + 1);
        chk("h2_truth_table", tt2, 8'h00);
        chk("h2_pass", pass2, 0);
        chk("h2_fail_valid", fv2, 1);
        chk("h2_fail_idx", fidx2, 1);
        chk("h2_busy_after", busy2, 0);

        // H=1, start held high: back-to-back sweeps
        start1 = 1'b1;
        perr = 0;
        for (int n = 1; n <= 45; n++) begin
            @(posedge clk); #1;
            abc_log[n] = {a1, b1, c1};
            if (done1) begin
                done_times.push_back(n);
                if (pass1 !== 1'b1 || tt1 !== 8'hEA) perr++;
            end
        end
        start1 = 1'b0;
        chk("h1_first_done", (done_times.size() > 0) ? done_times[0] : -1, 9);
        chk("h1_done_count", done_times.size(), 4);
        gap_err = 0;
        for (int i = 1; i < done_times.size(); i++)
            if (done_times[i] - done_times[i-1] != 10) gap_err++;
        chk("h1_done_interval_errs", gap_err, 0);
        chk("h1_pass_at_done_errs", perr, 0);
        seq1_err = 0;
        for (int k = 0; k < 8; k++) begin
            if (abc_log[1 + k]  !== 3'(k)) seq1_err++;
            if (abc_log[11 + k] !== 3'(k)) seq1_err++;
        end
        if (abc_log[9]  !== 3'd0) seq1_err++;
        if (abc_log[10] !== 3'd0) seq1_err++;
        if (abc_log[19] !== 3'd0) seq1_err++;
        chk("h1_abc_step_errs", seq1_err, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
